// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC, 1-cycle imem read, small queue towards decode.
// Define FETCH_PERF_EN to add the perf_fetched pop counter output.
module fetch_queue #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter int              QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     halt,
    input  logic [PC_W-1:0]          halt_pc,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic [PC_W-1:0]          out_pc_plus,
    output logic                     halted,
    output logic [$clog2(QDEPTH):0]  q_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perf_fetched
`endif
);
    localparam int              AW  = $clog2(QDEPTH);
    localparam int              CW  = AW + 1;
    localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e              state_q;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                infl_q;
    logic [PC_W-1:0]     infl_pc_q;
    logic [INSTR_W-1:0]  instr_mem_q [QDEPTH];
    logic [PC_W-1:0]     pc_mem_q [QDEPTH];
    logic [AW-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW:0]         occ;
    logic                run, flush, pop, push;
    logic [PC_W-1:0]     head_pc;

    assign run       = (state_q == RUN);
    assign flush     = halt | redirect;
    assign out_valid = run & (cnt_q != '0);
    assign pop       = out_valid & out_ready & ~flush;
    assign push      = infl_q & ~flush;

    // Occupancy after this edge, counting the read already in flight.
    assign occ      = {1'b0, cnt_q} + (CW+1)'(infl_q) - (CW+1)'(pop);
    assign imem_req = rst & run & ~flush & (occ < (CW+1)'(QDEPTH));

    assign imem_addr   = pc_q;
    assign head_pc     = pc_mem_q[rd_q];
    assign out_instr   = out_valid ? instr_mem_q[rd_q] : '0;
    assign out_pc      = out_valid ? head_pc : '0;
    assign out_pc_plus = out_valid ? head_pc + INC : '0;
    assign halted      = (state_q == HALTED);
    assign q_count     = cnt_q;

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        rd_d  = rd_q + AW'(pop);
        wr_d  = wr_q + AW'(push);
        if (halt) begin
            pc_d = halt_pc;
        end else if (redirect) begin
            pc_d = redirect_pc;
        end else if (imem_req) begin
            pc_d = pc_q + INC;
        end
        if (flush) begin
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
        end else begin
            if (halt) begin
                state_q <= HALTED;
            end else if (redirect) begin
                state_q <= RUN;
            end
            pc_q   <= pc_d;
            infl_q <= imem_req;
            if (imem_req) begin
                infl_pc_q <= pc_q;
            end
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_q] <= imem_rdata;
            pc_mem_q[wr_q]    <= infl_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (pop) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_fetched = perf_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an expected-PC scoreboard.
// imem model returns the read address as instruction data.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [15:0] halt_pc = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_pc_plus;
    logic        halted;
    logic [2:0]  q_count;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    fetch_queue #(
        .PC_W(16), .INSTR_W(16), .QDEPTH(4),
        .RESET_PC(16'h0000), .PC_INC(1)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .halt_pc(halt_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_pc_plus(out_pc_plus),
        .halted(halted), .q_count(q_count)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 16'(i));
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst && out_valid && out_ready && !halt && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_pop: observed pc %0h expected no output", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", {16'h0, out_pc}, {16'h0, e});
                check("pop_instr", {16'h0, out_instr}, {16'h0, e});
                check("pop_pc_plus", {16'h0, out_pc_plus}, {16'h0, e + 16'd1});
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        fill(16'h0000);
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_count", q_count, 0);
        check("rst_halted", halted, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_req", imem_req, 0);

        // Reset release and first-output latency
        tick(); rst = 1'b1;
        @(negedge clk);
        check("first_req", imem_req, 1);
        check("c0_valid", out_valid, 0);
        tick();
        @(negedge clk);
        check("c1_valid", out_valid, 0);
        tick();
        @(negedge clk);
        check("c2_valid", out_valid, 1);
        check("c2_pc", out_pc, 0);
        repeat (6) tick();
        @(negedge clk);
        check("steady_count", q_count, 1);

        // Redirect with 3 queued entries and one read in flight
        tick(); out_ready = 1'b0;
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040; out_ready = 1'b1;
        fill(16'h0040);
        @(negedge clk);
        check("pre_redir_count", q_count, 3);
        check("redir_req", imem_req, 0);
        tick(); redirect = 1'b0;
        @(negedge clk);
        check("redir_flush_count", q_count, 0);
        check("redir_t1_valid", out_valid, 0);
        check("redir_t1_req", imem_req, 1);
        check("redir_t1_addr", imem_addr, 16'h0040);
        tick();
        @(negedge clk);
        check("redir_t2_valid", out_valid, 0);
        tick();
        @(negedge clk);
        check("redir_t3_valid", out_valid, 1);
        check("redir_t3_pc", out_pc, 16'h0040);

        // Back-pressure: queue saturates, then resumes
        repeat (5) tick();
        out_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("bp_count", q_count, 4);
        check("bp_req", imem_req, 0);
        check("bp_valid", out_valid, 1);
        tick(); out_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_req", imem_req, 1);
        repeat (8) tick();

        // Halt wins over simultaneous redirect
        tick();
        halt = 1'b1; halt_pc = 16'h00FF;
        redirect = 1'b1; redirect_pc = 16'h1234;
        exp_q.delete();
        tick(); halt = 1'b0; redirect = 1'b0;
        @(negedge clk);
        check("halt_state", halted, 1);
        check("halt_req", imem_req, 0);
        check("halt_addr", imem_addr, 16'h00FF);
        check("halt_valid", out_valid, 0);
        check("halt_count", q_count, 0);
        repeat (3) tick();
        @(negedge clk);
        check("halt_sticky", halted, 1);
        check("halt_sticky_req", imem_req, 0);
        tick(); redirect = 1'b1; redirect_pc = 16'h0010;
        fill(16'h0010);
        tick(); redirect = 1'b0;
        @(negedge clk);
        check("unhalt_state", halted, 0);
        check("unhalt_addr", imem_addr, 16'h0010);
        tick();
        tick();
        @(negedge clk);
        check("unhalt_valid", out_valid, 1);
        check("unhalt_pc", out_pc, 16'h0010);
        repeat (3) tick();

        // PC wrap-around
        tick(); redirect = 1'b1; redirect_pc = 16'hFFFE;
        fill(16'hFFFE);
        tick(); redirect = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("wrap_pc0", out_pc, 16'hFFFE);
        tick();
        @(negedge clk);
        check("wrap_pc1", out_pc, 16'hFFFF);
        check("wrap_plus1", out_pc_plus, 16'h0000);
        tick();
        @(negedge clk);
        check("wrap_pc2", out_pc, 16'h0000);
        repeat (3) tick();

        // Mid-run reset, then 5 pops and halt
        tick(); rst = 1'b0;
        exp_q.delete();
        tick(); rst = 1'b1;
        fill(16'h0000);
        @(negedge clk);
        check("mrst_count", q_count, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_addr", imem_addr, 0);
`ifdef FETCH_PERF_EN
        check("mrst_perf", perf_fetched, 0);
`endif
        repeat (7) tick();
        halt = 1'b1; halt_pc = 16'h0000;
        tick(); halt = 1'b0;
        @(negedge clk);
        check("perf_halted", halted, 1);
`ifdef FETCH_PERF_EN
        check("perf_five", perf_fetched, 5);
`endif
        tick(); rst = 1'b0;
        tick(); rst = 1'b1;
        @(negedge clk);
        check("final_rst_halted", halted, 0);
`ifdef FETCH_PERF_EN
        check("perf_cleared", perf_fetched, 0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage: holds the program counter, issues one read per cycle to a synchronous single-port instruction memory (1-cycle read latency), and buffers returned instructions with their PCs in a small queue that decode drains through a valid/ready handshake. It replaces the single-register fetch stage and adds back-pressure, redirect squashing of in-flight reads, and a sticky halted state. It sits between the instruction RAM and the decode stage.

## Interface
- PC_W, 16, PC and address width
- INSTR_W, 16, instruction width
- QDEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, PC value loaded on reset
- PC_INC, 1, PC increment per instruction

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- redirect  in  1  jump/branch taken; load redirect_pc
- redirect_pc  in  PC_W  redirect target
- halt  in  1  halt request; load halt_pc and stop fetching
- halt_pc  in  PC_W  PC value held while halted
- imem_req  out  1  read issued this cycle
- imem_addr  out  PC_W  read address (= fetch PC)
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_req
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  PC_W  head PC
- out_pc_plus  out  PC_W  out_pc + PC_INC, modulo 2^PC_W
- halted  out  1  in HALTED state
- q_count  out  $clog2(QDEPTH)+1  entries held

## Operation
- States: RUN, HALTED. Reset → RUN, PC=RESET_PC, queue empty, no in-flight read, all outputs 0 except imem_addr=RESET_PC.
- Pop: out_valid & out_ready; head removed at clock edge.
- Credit: imem_req = RUN & !halt & !redirect & (q_count + inflight − pop < QDEPTH). Queue never overflows; imem_rdata never dropped for lack of space.
- Issue: imem_req → PC ← PC + PC_INC (wraps); address tagged into a one-entry in-flight register (pc, valid, squash).
- Return: cycle after issue, if not squashed, {imem_rdata, tagged pc} pushed at tail. Push and pop in same cycle permitted at any occupancy.
- Redirect (RUN or HALTED): queue flushed, in-flight read squashed, PC ← redirect_pc, state → RUN.
- Halt: priority over redirect. Queue flushed, in-flight squashed, PC ← halt_pc, state → HALTED. In HALTED, imem_req=0, out_valid=0, imem_addr=halt_pc. Only redirect or reset leaves HALTED.
- Flushes take effect at the edge where halt/redirect is sampled; head present that cycle is not popped even if out_ready=1.

## Timing
- Redirect sampled at edge t: imem_req with redirect_pc in cycle t+1, data t+2, out_valid at t+3 (3-cycle redirect penalty).
- From reset release: first out_valid 2 cycles after the first cycle rst=1.
- Sustained throughput: 1 instruction/cycle with out_ready held high, for any QDEPTH ≥2.
- out_ready low: issue stops once q_count + inflight = QDEPTH; resumes same cycle out_ready rises (pop term in credit).
- No combinational path from imem_rdata to out_*; out_valid, out_instr, out_pc registered. imem_req depends combinationally on halt, redirect, out_ready.
- Reset mid-operation: next cycle identical to post-reset state; in-flight data ignored.

## Configuration
- FETCH_PERF_EN defined: adds output perf_fetched [31:0], counts pops, reset to 0, wraps at 2^32; not cleared by redirect/halt.
- Undefined: port and counter absent; remaining behaviour identical.

## Test plan
- Reset, RESET_PC=0, out_ready=1, imem returns addr as data → out_pc 0,1,2,3… on consecutive cycles, out_pc_plus = out_pc+1, first out_valid 2 cycles after rst rises.
- out_ready=0 for 10 cycles, QDEPTH=4 → q_count saturates at 4, imem_req low, no lost/duplicated entries after release; sequence contiguous.
- redirect to 0x0040 while queue holds 3 entries and one read in flight → q_count 0 next cycle, squashed data never appears, out_pc=0x0040 three cycles later.
- halt with halt_pc=0x00FF and redirect same cycle → halted=1, imem_req=0, imem_addr=0x00FF; later redirect to 0x0010 → halted=0, out_pc=0x0010 after 3 cycles.
- PC_W=16, redirect to 0xFFFE, PC_INC=1 → out_pc 0xFFFE, 0xFFFF, 0x0000; out_pc_plus of 0xFFFF = 0x0000.
- FETCH_PERF_EN, 5 pops then halt → perf_fetched=5; rst low one cycle → 0.
